// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
// Imported by serial_subtractor; full_subtractor is purely combinational and needs nothing here.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin (mod 2), bout = borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when the subtrahend plus incoming borrow exceeds the minuend bit.
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin, one bit per cycle through a single cell.
// Latency: accepted start at edge T gives done (and new diff/bout/ovf) after edge T+WIDTH+1.
// Backpressure: start is ignored while busy; result held until the next accepted start.
// Ports: clk, rst (sync, active-high), start, a, b, bin -> busy, done, diff, bout, ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            // Input MSBs are kept aside because the shifters lose them.
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          // Result bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
          r_sh_q <= {cell_d, r_sh_q[WIDTH-1:1]};
          br_q   <= cell_bout;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          diff_q  <= r_sh_q;
          bout_q  <= br_q;
          // Signed overflow: operands of opposite sign and result sign differs from minuend.
          ovf_q   <= (a_msb_q != b_msb_q) && (r_sh_q[WIDTH-1] != a_msb_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances) and the full_subtractor cell.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  // WIDTH=4 instance for the exhaustive sweep
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  // Standalone cell
  logic fs_a = 1'b0, fs_b = 1'b0, fs_c = 1'b0;
  logic fs_d, fs_bout;

  full_subtractor u_fs (.a(fs_a), .b(fs_b), .bin(fs_c), .d(fs_d), .bout(fs_bout));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge with dut8 idle. Returns done latency and busy-cycle count.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     output int lat, output int bcnt);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    // Scramble inputs while busy: only captured values may matter.
    a8 = ~av; b8 = ~bv; bin8 = ~bi;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi, output int lat);
    a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] a, b;
    logic       bi;
    logic [7:0] d;
    logic       bo, ov;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, bcnt, ndone, d1, d2;
    vecs[0] = '{"basic",   8'd5,  8'd3,  1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{"wrap",    8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{"ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{"ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{"bin_0",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{"bin_ff",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    // Cell truth table
    for (int i = 0; i < 8; i++) begin
      int v;
      {fs_a, fs_b, fs_c} = 3'(i);
      #1;
      v = int'(fs_a) - int'(fs_b) - int'(fs_c);
      chk($sformatf("cell_d_%0d", i), 32'(fs_d), 32'(v & 1));
      chk($sformatf("cell_bout_%0d", i), 32'(fs_bout), 32'(v < 0));
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bout8), 0);
    chk("rst_ovf",  32'(ovf8),  0);

    // Directed vectors
    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].bi, lat, bcnt);
      chk({vecs[i].name, "_lat"},  32'(lat),   9);
      chk({vecs[i].name, "_busy"}, 32'(bcnt),  8);
      chk({vecs[i].name, "_diff"}, 32'(diff8), 32'(vecs[i].d));
      chk({vecs[i].name, "_bout"}, 32'(bout8), 32'(vecs[i].bo));
      chk({vecs[i].name, "_ovf"},  32'(ovf8),  32'(vecs[i].ov));
    end
    // Result holds after done drops
    repeat (3) @(posedge clk); #1;
    chk("hold_diff", 32'(diff8), 32'h FF);
    chk("hold_done", 32'(done8), 0);

    // Second start while busy is ignored
    a8 = 8'd10; b8 = 8'd4; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    ndone = 0;
    for (int k = 4; k < 25; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        chk("hs_lat", 32'(k), 9);
        chk("hs_diff", 32'(diff8), 6);
      end
    end
    chk("hs_ndone", 32'(ndone), 1);

    // Start held high: back-to-back operations
    a8 = 8'd9; b8 = 8'd3; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    ndone = 0; d1 = -1; d2 = -1;
    for (int k = 1; k < 40 && ndone < 2; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (ndone == 1) d1 = k; else d2 = k;
      end
    end
    start8 = 1'b0;
    chk("held_ndone", 32'(ndone), 2);
    chk("held_first", 32'(d1), 9);
    chk("held_gap", 32'(d2 - d1), 10);
    chk("held_diff", 32'(diff8), 6);
    repeat (12) @(posedge clk); #1;
    chk("held_idle", 32'(busy8), 0);

    // Reset mid-operation
    a8 = 8'd20; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 0);
    chk("mid_rst_diff", 32'(diff8), 0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 0);
    op8(8'h55, 8'h22, 1'b0, lat, bcnt);
    chk("post_rst_lat",  32'(lat),   9);
    chk("post_rst_diff", 32'(diff8), 32'h33);
    chk("post_rst_bout", 32'(bout8), 0);

    // Exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      logic [3:0] av, bv, ed;
      logic       bi, eb, eo;
      logic [4:0] full;
      av = 4'(i >> 5); bv = 4'(i >> 1); bi = 1'(i);
      full = {1'b0, av} - {1'b0, bv} - {4'b0, bi};
      ed = full[3:0];
      eb = full[4];
      eo = (av[3] != bv[3]) && (ed[3] != av[3]);
      op4(av, bv, bi, lat);
      chk($sformatf("x4_lat_%0h_%0h_%0d", av, bv, bi), 32'(lat), 5);
      chk($sformatf("x4_diff_%0h_%0h_%0d", av, bv, bi), 32'(diff4), 32'(ed));
      chk($sformatf("x4_bout_%0h_%0h_%0d", av, bv, bi), 32'(bout4), 32'(eb));
      chk($sformatf("x4_ovf_%0h_%0h_%0d", av, bv, bi), 32'(ovf4), 32'(eo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
- One full-subtractor cell is reused each cycle, with a registered borrow between cycles.
- Companion to the team's full-adder (sum/carry) cell on the subtract side. Used where area matters more than latency.
- Host interface is a start/busy/done handshake. The result is held stable until the next accepted start.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal range 2..32.
- CW, $clog2(WIDTH+1): width of the internal bit counter.

Ports:
- clk   input   1      rising-edge clock.
- rst   input   1      reset.
- start input   1      request. Sampled only when busy=0.
- a     input   WIDTH  minuend. Captured on an accepted start.
- b     input   WIDTH  subtrahend. Captured on an accepted start.
- bin   input   1      borrow-in. Captured on an accepted start.
- busy  output  1      high while bits are being processed.
- done  output  1      one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result. Held until the next accepted start.
- bout  output  1      unsigned borrow-out: 1 iff a < b + bin.
- ovf   output  1      two's-complement signed overflow of a - b - bin.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, borrow register=0, a_sh=0, b_sh=0.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1: load a_sh=a, b_sh=b, br=bin, a_msb=a[WIDTH-1], b_msb=b[WIDTH-1], cnt=0.
  - Go to SHIFT; busy=1 from the next cycle.
  - diff/bout/ovf keep their previous values until FINISH.
- SHIFT, once per cycle:
  - d = a_sh[0]^b_sh[0]^br.
  - br <= (~a_sh[0]&b_sh[0]) | (~a_sh[0]&br) | (b_sh[0]&br).
  - a_sh and b_sh shift right by 1. d shifts into the MSB of the result shift register r_sh.
  - cnt++. When cnt reaches WIDTH-1 (the last bit processed this cycle), go to FINISH.
- FINISH, one cycle:
  - diff <= r_sh, bout <= br.
  - ovf <= (a_msb != b_msb) && (r_sh[WIDTH-1] != a_msb).
  - done=1 for this cycle only, busy=0. Return to IDLE.
- Latency:
  - Accepted start at edge T → done high during cycle T+WIDTH+1; diff valid from that cycle.
  - Back-to-back: the next start is accepted in the cycle after done. Throughput is one result per WIDTH+2 cycles.
- start while busy=1 (SHIFT or FINISH) is ignored. No queuing, and operands are not re-sampled.
- start held high continuously: a new operation begins in each IDLE cycle.
- Inputs a/b/bin may change freely while busy. Only the values captured at accept matter.
- rst during SHIFT/FINISH: the operation is aborted and all registers return to their reset values. No done pulse.
- Arithmetic:
  - Modulo 2^WIDTH; diff equals (a - b - bin) mod 2^WIDTH.
  - bout and ovf follow standard subtractor semantics; ovf compares the MSBs of the inputs with the MSB of the result.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package:
  - State encoding enum: IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2.
  - The default WIDTH constant.
- Natural sub-module: full_subtractor, a combinational 1-bit cell with inputs (a, b, bin) and outputs (d, bout).
  - It mirrors the existing adder cell.
  - It is instantiated once and is independently unit-testable over all 8 input combinations.

Test Plan:
- Basic: WIDTH=8, a=8'd5, b=8'd3, bin=0, start pulse → done at T+9, diff=8'h02, bout=0, ovf=0. busy high for cycles T+1..T+8.
- Wrap: a=8'd3, b=8'd5, bin=0 → diff=8'hFE, bout=1, ovf=0.
- Signed overflow: a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1. Also a=8'h7F, b=8'hFF → diff=8'h80, bout=1, ovf=1.
- Borrow-in: a=0, b=0, bin=1 → diff=8'hFF, bout=1, ovf=0. Also a=8'hFF, b=8'hFF, bin=1 → diff=8'hFF, bout=1.
- Handshake: start with a=10, b=4; pulse start again at T+3 with a=1, b=2 → the second start is ignored, a single done gives diff=6. Start held high across two operations → two done pulses WIDTH+2 cycles apart.
- Reset mid-op: assert rst at T+4 for one cycle → busy=0, done never pulses, diff=0. A fresh start then completes normally.
- Exhaustive (WIDTH=4): all a, b, bin combinations compared against a reference model, checking diff, bout and ovf.
